// File: rtl/pbus_pkg.sv
// Shared definitions for the peripheral-bus bridge: slot address map, FSM
// states, bridge register offsets and STATUS bit positions.
package pbus_pkg;

  localparam int MAX_DEV = 8;

  // Word addresses [31:2]; each slot owns one 256-byte page (byte bits [31:8]).
  localparam logic [29:0] DEV_BASE [MAX_DEV] = '{
    30'h0000_1FC0, 30'h0000_2000, 30'h0000_2040, 30'h0000_2080,
    30'h0000_20C0, 30'h0000_2100, 30'h0000_2140, 30'h0000_2180
  };
  localparam logic [29:0] DEV_MASK [MAX_DEV] = '{default: 30'h3FFF_FFC0};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } stateT;

  localparam logic [1:0] REG_STATUS   = 2'd0;
  localparam logic [1:0] REG_ERR_ADDR = 2'd1;
  localparam logic [1:0] REG_INT_MASK = 2'd2;
  localparam logic [1:0] REG_ERR_IE   = 2'd3;

  localparam int ST_ERR     = 0;
  localparam int ST_NOHIT   = 1;
  localparam int ST_TIMEOUT = 2;

endpackage

// File: rtl/pbus_irq_agg.sv
// Masks device interrupts, folds slots 5 and up plus the bus-error interrupt
// onto the top CPU line, and registers the result.
module pbus_irq_agg
  import pbus_pkg::*;
#(
  parameter int NUM_DEV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_DEV-1:0] devInt,
  input  logic [NUM_DEV-1:0] intMask,
  input  logic               errIrq,
  output logic [5:0]         hwInt
);

  logic [MAX_DEV-1:0] masked;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    masked = '0;
    masked[NUM_DEV-1:0] = devInt & intMask;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hwInt <= '0;
    else     hwInt <= {(|masked[7:5]) | errIrq, masked[4:0]};
  end

endmodule

// File: rtl/pbus_bridge.sv
// CPU-to-peripheral bridge: address decode, one-cycle device strobes, ready
// wait with timeout, bridge register block with error capture, interrupts.
module pbus_bridge
  import pbus_pkg::*;
#(
  parameter int          NUM_DEV     = 4,
  parameter int          TIMEOUT     = 15,
  parameter logic [29:0] BRIDGE_BASE = 30'h3FFF_FF00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [29:0]            PrAddr,
  input  logic [31:0]            PrWD,
  input  logic [3:0]             PrBE,
  input  logic                   PrWe,
  input  logic                   PrRd,
  output logic [31:0]            PrRD,
  output logic                   PrRdy,
  output logic                   PrErr,
  output logic [29:0]            DevAddr,
  output logic [31:0]            DevWD,
  output logic [3:0]             DevBE,
  output logic [NUM_DEV-1:0]     DevWe,
  output logic [NUM_DEV-1:0]     DevRe,
  input  logic [32*NUM_DEV-1:0]  DevRD,
  input  logic [NUM_DEV-1:0]     DevRdy,
  input  logic [NUM_DEV-1:0]     DevInt,
  output logic [5:0]             HWInt
);

  stateT              state, stateNext;
  logic [7:0]         waitCnt;
  logic [NUM_DEV-1:0] selHot, hitHot, intMask;
  logic               opWe, errFlag, errIe, strobe;
  logic [31:0]        rdData, devRdSel, bridgeRd;
  logic [2:0]         status, statusSet, statusClr;
  logic [29:0]        errAddr;
  logic               req, devHit, bridgeHit, noHit, devReady, timeoutHit, bridgeWr;
  logic [1:0]         regSel;

  assign req        = PrWe | PrRd;
  assign regSel     = PrAddr[1:0];
  assign bridgeHit  = (PrAddr[29:2] == BRIDGE_BASE[29:2]);
  assign devHit     = |hitHot;
  assign noHit      = ~devHit & ~bridgeHit;
  assign devReady   = |(DevRdy & selHot);
  assign timeoutHit = (waitCnt == 8'(TIMEOUT - 1));
  assign bridgeWr   = (state == IDLE) & req & devHit == 1'b0 & bridgeHit & PrWe;

  // Descending scan so the lowest matching slot is the one left standing.
  always_comb begin
    hitHot = '0;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      if ((PrAddr & DEV_MASK[i]) == DEV_BASE[i]) begin
        hitHot    = '0;
        hitHot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    devRdSel = '0;
    for (int i = 0; i < NUM_DEV; i++)
      if (selHot[i]) devRdSel = devRdSel | DevRD[32*i +: 32];
  end

  always_comb begin
    bridgeRd = '0;
    case (regSel)
      REG_STATUS:   bridgeRd[2:0] = status;
      REG_ERR_ADDR: bridgeRd = {errAddr, 2'b00};
      REG_INT_MASK: bridgeRd[NUM_DEV-1:0] = intMask;
      default:      bridgeRd[0] = errIe;
    endcase
  end

  always_comb begin
    statusSet = '0;
    if ((state == IDLE && req && noHit) ||
        (state == ACCESS && !devReady && timeoutHit)) begin
      statusSet[ST_ERR] = 1'b1;
      if (state == IDLE) statusSet[ST_NOHIT]   = 1'b1;
      else               statusSet[ST_TIMEOUT] = 1'b1;
    end
  end

  assign statusClr = (bridgeWr && regSel == REG_STATUS && PrBE[0]) ? PrWD[2:0] : 3'b000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (req) stateNext = devHit ? ACCESS : RESP;
      ACCESS:  if (devReady || timeoutHit) stateNext = RESP;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    strobe = (state == ACCESS) && (waitCnt == 8'd0);
    PrRdy  = (state == RESP);
    PrErr  = PrRdy & errFlag;
    PrRD   = rdData;
    DevWe  = (strobe &&  opWe) ? selHot : '0;
    DevRe  = (strobe && !opWe) ? selHot : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DevAddr <= '0;
      DevWD   <= '0;
      DevBE   <= '0;
      opWe    <= 1'b0;
      selHot  <= '0;
      waitCnt <= '0;
      rdData  <= '0;
      errFlag <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          DevAddr <= PrAddr;
          DevWD   <= PrWD;
          DevBE   <= PrBE;
          opWe    <= PrWe;
          selHot  <= hitHot;
          waitCnt <= '0;
          errFlag <= noHit;
          rdData  <= (bridgeHit && !devHit && !PrWe) ? bridgeRd : '0;
        end
        ACCESS: begin
          waitCnt <= waitCnt + 8'd1;
          if (devReady) begin
            rdData  <= opWe ? '0 : devRdSel;
            errFlag <= 1'b0;
          end else if (timeoutHit) begin
            rdData  <= '0;
            errFlag <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A freshly detected error outranks a same-cycle write-1-to-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status  <= '0;
      errAddr <= '0;
      intMask <= '1;
      errIe   <= 1'b0;
    end else begin
      status <= (status & ~statusClr) | statusSet;
      if (|statusSet) errAddr <= (state == IDLE) ? PrAddr : DevAddr;
      if (bridgeWr && PrBE[0]) begin
        if (regSel == REG_INT_MASK) intMask <= PrWD[NUM_DEV-1:0];
        if (regSel == REG_ERR_IE)   errIe   <= PrWD[0];
      end
    end
  end

  pbus_irq_agg #(.NUM_DEV(NUM_DEV)) u_irq (
    .clk     (clk),
    .rst     (rst),
    .devInt  (DevInt),
    .intMask (intMask),
    .errIrq  (status[ST_ERR] & errIe),
    .hwInt   (HWInt)
  );

endmodule

// File: tb/tb_pbus_bridge.sv
// Directed bench for pbus_bridge: table of bus transactions with hand-derived
// latency/data/error/strobe expectations, plus interrupt, back-to-back and reset sequences.
module tb_pbus_bridge;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [29:0]  PrAddr = '0;
  logic [31:0]  PrWD = '0;
  logic [3:0]   PrBE = '0;
  logic         PrWe = 1'b0, PrRd = 1'b0;
  logic [31:0]  PrRD;
  logic         PrRdy, PrErr;
  logic [29:0]  DevAddr;
  logic [31:0]  DevWD;
  logic [3:0]   DevBE, DevWe, DevRe, DevRdy;
  logic [3:0]   DevInt = '0;
  logic [127:0] DevRD;
  logic [5:0]   HWInt;

  int nChecks = 0;
  int nErrors = 0;
  int waitLeft = 0;
  bit armed = 0;
  bit devStuck = 0;

  always #5 clk = ~clk;

  assign DevRD  = {32'h0000_1234, 32'hCAFE_0002, 32'hBEEF_0001, 32'hDEAD_0000};
  assign DevRdy = (!devStuck && waitLeft == 0) ? 4'hF : 4'h0;

  // Device model: ready returns waitLeft cycles after the strobe cycle.
  always @(negedge clk) begin
    if (armed && waitLeft > 0) waitLeft--;
    if (|DevWe || |DevRe) armed = 1;
  end

  pbus_bridge #(.NUM_DEV(4), .TIMEOUT(15), .BRIDGE_BASE(30'h3FFF_FF00)) dut (
    .clk(clk), .rst(rst), .PrAddr(PrAddr), .PrWD(PrWD), .PrBE(PrBE),
    .PrWe(PrWe), .PrRd(PrRd), .PrRD(PrRD), .PrRdy(PrRdy), .PrErr(PrErr),
    .DevAddr(DevAddr), .DevWD(DevWD), .DevBE(DevBE), .DevWe(DevWe), .DevRe(DevRe),
    .DevRD(DevRD), .DevRdy(DevRdy), .DevInt(DevInt), .HWInt(HWInt)
  );

  typedef struct {
    logic        we, rd;
    logic [29:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    int          waitCycles;
    logic        stuck;
    int          expLat;
    logic [31:0] expRd;
    logic        expErr;
    logic [3:0]  expWe, expRe;
  } vecT;

  localparam logic [29:0] A_STATUS = 30'h3FFF_FF00;
  localparam logic [29:0] A_ERRADR = 30'h3FFF_FF01;
  localparam logic [29:0] A_INTMSK = 30'h3FFF_FF02;
  localparam logic [29:0] A_ERRIE  = 30'h3FFF_FF03;
  localparam logic [29:0] A_NOHIT  = 30'h0000_0100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic vecT mk(input logic we, input logic rd, input logic [29:0] addr,
                             input logic [31:0] wd, input logic [3:0] be, input int w,
                             input logic stuck, input int lat, input logic [31:0] expRd,
                             input logic err, input logic [3:0] expWe, input logic [3:0] expRe);
    vecT v;
    v.we = we; v.rd = rd; v.addr = addr; v.wd = wd; v.be = be; v.waitCycles = w;
    v.stuck = stuck; v.expLat = lat; v.expRd = expRd; v.expErr = err;
    v.expWe = expWe; v.expRe = expRe;
    return v;
  endfunction

  // Entered and left #1 after a rising edge; lat counts cycles from the request cycle.
  task automatic doAccess(input vecT v, output int lat, output logic [31:0] rdv, output logic errv,
                          output logic [3:0] weSeen, output logic [3:0] reSeen,
                          output int strobes, output logic [31:0] wdSeen);
    bit done = 0;
    PrWe = v.we; PrRd = v.rd; PrAddr = v.addr; PrWD = v.wd; PrBE = v.be;
    waitLeft = v.waitCycles; devStuck = v.stuck; armed = 0;
    lat = 0; rdv = '0; errv = 0; weSeen = '0; reSeen = '0; strobes = 0; wdSeen = '0;
    while (!done) begin
      @(negedge clk);
      if (|DevWe || |DevRe) begin
        weSeen |= DevWe; reSeen |= DevRe; strobes++; wdSeen = DevWD;
      end
      if (PrRdy) begin
        rdv = PrRD; errv = PrErr; done = 1;
      end else if (lat >= 40) begin
        check("rdy_wait_bound", 32'(lat), 32'(v.expLat));
        done = 1;
      end else begin
        @(posedge clk); #1; lat++;
      end
    end
    @(posedge clk); #1;
    PrWe = 0; PrRd = 0; devStuck = 0; waitLeft = 0;
    @(negedge clk);
    check("rdy_one_cycle", {31'b0, PrRdy}, 32'd0);
    @(posedge clk); #1;
  endtask

  vecT vecs [23];

  initial begin
    int lat, strobes;
    logic [31:0] rdv, wdSeen;
    logic errv;
    logic [3:0] weSeen, reSeen, pattern, strobeAcc;
    logic rdyAcc;

    //               we rd addr          wd            be     w stuck lat rd            err we      re
    vecs[0]  = mk(1, 0, 30'h0000_2000, 32'h0000_00A5, 4'hF, 0, 0,  2, 32'h0,          0, 4'b0010, 4'b0000);
    vecs[1]  = mk(0, 1, 30'h0000_2080, 32'h0,         4'hF, 3, 0,  5, 32'h0000_1234,  0, 4'b0000, 4'b1000);
    vecs[2]  = mk(0, 1, 30'h0000_1FC5, 32'h0,         4'hF, 0, 0,  2, 32'hDEAD_0000,  0, 4'b0000, 4'b0001);
    vecs[3]  = mk(0, 1, 30'h0000_2040, 32'h0,         4'hF, 0, 1, 16, 32'h0,          1, 4'b0000, 4'b0100);
    vecs[4]  = mk(0, 1, A_STATUS,      32'h0,         4'hF, 0, 0,  1, 32'h5,          0, 4'b0000, 4'b0000);
    vecs[5]  = mk(0, 1, A_ERRADR,      32'h0,         4'hF, 0, 0,  1, 32'h0000_8100,  0, 4'b0000, 4'b0000);
    vecs[6]  = mk(0, 1, A_NOHIT,       32'h0,         4'hF, 0, 0,  1, 32'h0,          1, 4'b0000, 4'b0000);
    vecs[7]  = mk(0, 1, A_STATUS,      32'h0,         4'hF, 0, 0,  1, 32'h7,          0, 4'b0000, 4'b0000);
    vecs[8]  = mk(0, 1, A_ERRADR,      32'h0,         4'hF, 0, 0,  1, 32'h0000_0400,  0, 4'b0000, 4'b0000);
    vecs[9]  = mk(1, 0, A_STATUS,      32'h1,         4'hF, 0, 0,  1, 32'h0,          0, 4'b0000, 4'b0000);
    vecs[10] = mk(0, 1, A_STATUS,      32'h0,         4'hF, 0, 0,  1, 32'h6,          0, 4'b0000, 4'b0000);
    vecs[11] = mk(1, 0, A_STATUS,      32'h7,         4'hE, 0, 0,  1, 32'h0,          0, 4'b0000, 4'b0000);
    vecs[12] = mk(0, 1, A_STATUS,      32'h0,         4'hF, 0, 0,  1, 32'h6,          0, 4'b0000, 4'b0000);
    vecs[13] = mk(1, 0, A_STATUS,      32'h7,         4'h1, 0, 0,  1, 32'h0,          0, 4'b0000, 4'b0000);
    vecs[14] = mk(0, 1, A_STATUS,      32'h0,         4'hF, 0, 0,  1, 32'h0,          0, 4'b0000, 4'b0000);
    vecs[15] = mk(0, 1, A_INTMSK,      32'h0,         4'hF, 0, 0,  1, 32'hF,          0, 4'b0000, 4'b0000);
    vecs[16] = mk(0, 1, A_ERRIE,       32'h0,         4'hF, 0, 0,  1, 32'h0,          0, 4'b0000, 4'b0000);
    vecs[17] = mk(1, 0, A_INTMSK,      32'hFFFF_FFFB, 4'hF, 0, 0,  1, 32'h0,          0, 4'b0000, 4'b0000);
    vecs[18] = mk(0, 1, A_INTMSK,      32'h0,         4'hF, 0, 0,  1, 32'hB,          0, 4'b0000, 4'b0000);
    vecs[19] = mk(1, 0, A_ERRIE,       32'h1,         4'hF, 0, 0,  1, 32'h0,          0, 4'b0000, 4'b0000);
    vecs[20] = mk(0, 1, A_ERRIE,       32'h0,         4'hF, 0, 0,  1, 32'h1,          0, 4'b0000, 4'b0000);
    vecs[21] = mk(0, 1, 30'h0000_2001, 32'h0,         4'hF, 2, 0,  4, 32'hBEEF_0001,  0, 4'b0000, 4'b0010);
    vecs[22] = mk(1, 1, 30'h0000_2083, 32'h0000_5A5A, 4'h3, 1, 0,  3, 32'h0,          0, 4'b1000, 4'b0000);

    // Reset values while rst is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_PrRD",    PrRD, 32'h0);
    check("rst_PrRdy",   {31'b0, PrRdy}, 32'h0);
    check("rst_PrErr",   {31'b0, PrErr}, 32'h0);
    check("rst_strobes", {24'b0, DevWe, DevRe}, 32'h0);
    check("rst_DevAddr", {2'b0, DevAddr}, 32'h0);
    check("rst_DevWD",   DevWD, 32'h0);
    check("rst_DevBE",   {28'b0, DevBE}, 32'h0);
    check("rst_HWInt",   {26'b0, HWInt}, 32'h0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 23; i++) begin
      doAccess(vecs[i], lat, rdv, errv, weSeen, reSeen, strobes, wdSeen);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].expLat));
      check($sformatf("v%0d_PrErr", i), {31'b0, errv}, {31'b0, vecs[i].expErr});
      if (!vecs[i].we)
        check($sformatf("v%0d_PrRD", i), rdv, vecs[i].expRd);
      check($sformatf("v%0d_DevWe", i), {28'b0, weSeen}, {28'b0, vecs[i].expWe});
      check($sformatf("v%0d_DevRe", i), {28'b0, reSeen}, {28'b0, vecs[i].expRe});
      check($sformatf("v%0d_strobe_cycles", i), 32'(strobes),
            (|vecs[i].expWe || |vecs[i].expRe) ? 32'd1 : 32'd0);
      if (|vecs[i].expWe)
        check($sformatf("v%0d_DevWD", i), wdSeen, vecs[i].wd);
    end

    // Interrupts: mask is 4'b1011, ERR_IE is 1, STATUS is clear.
    check("irq_idle", {26'b0, HWInt}, 32'h0);
    DevInt = 4'b1111;
    @(negedge clk);
    check("irq_not_yet", {26'b0, HWInt}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("irq_masked", {26'b0, HWInt}, 32'b001011);
    @(posedge clk); #1;
    DevInt = 4'b0000;
    doAccess(mk(0, 1, A_NOHIT, 32'h0, 4'hF, 0, 0, 1, 32'h0, 1, 4'h0, 4'h0),
             lat, rdv, errv, weSeen, reSeen, strobes, wdSeen);
    check("irq_err_lat", 32'(lat), 32'd1);
    @(negedge clk);
    check("irq_err_ie", {26'b0, HWInt}, 32'b100000);
    @(posedge clk); #1;
    doAccess(mk(1, 0, A_STATUS, 32'h7, 4'hF, 0, 0, 1, 32'h0, 0, 4'h0, 4'h0),
             lat, rdv, errv, weSeen, reSeen, strobes, wdSeen);
    @(negedge clk);
    check("irq_err_cleared", {26'b0, HWInt}, 32'h0);
    @(posedge clk); #1;

    // Back-to-back: request held past PrRdy starts a second access.
    PrRd = 1; PrAddr = A_INTMSK;
    pattern = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      pattern[c] = PrRdy;
      @(posedge clk); #1;
    end
    PrRd = 0;
    check("b2b_rdy_pattern", {28'b0, pattern}, 32'b1010);
    check("b2b_PrRD", PrRD, 32'hB);
    @(posedge clk); #1;

    // Reset during ACCESS.
    DevInt = 4'b0001;
    PrRd = 1; PrAddr = 30'h0000_2040; devStuck = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstacc_strobe", {28'b0, DevRe}, 32'b0100);
    check("rstacc_hwint_pre", {26'b0, HWInt}, 32'b000001);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1; PrRd = 0; DevInt = 4'b0000;
    #1;
    check("rstacc_PrRdy",   {31'b0, PrRdy}, 32'h0);
    check("rstacc_PrErr",   {31'b0, PrErr}, 32'h0);
    check("rstacc_DevRe",   {28'b0, DevRe}, 32'h0);
    check("rstacc_DevAddr", {2'b0, DevAddr}, 32'h0);
    check("rstacc_HWInt",   {26'b0, HWInt}, 32'h0);
    @(posedge clk); #1;
    rst = 0; devStuck = 0;
    rdyAcc = 0; strobeAcc = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      rdyAcc |= PrRdy;
      strobeAcc |= DevWe | DevRe;
      @(posedge clk); #1;
    end
    check("rstacc_no_rdy",    {31'b0, rdyAcc}, 32'h0);
    check("rstacc_no_strobe", {28'b0, strobeAcc}, 32'h0);
    doAccess(mk(0, 1, A_INTMSK, 32'h0, 4'hF, 0, 0, 1, 32'hF, 0, 4'h0, 4'h0),
             lat, rdv, errv, weSeen, reSeen, strobes, wdSeen);
    check("rstacc_intmask", rdv, 32'hF);
    doAccess(mk(0, 1, A_STATUS, 32'h0, 4'hF, 0, 0, 1, 32'h0, 0, 4'h0, 4'h0),
             lat, rdv, errv, weSeen, reSeen, strobes, wdSeen);
    check("rstacc_status", rdv, 32'h0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", nChecks);
    $fatal(1);
  end

endmodule

// File: doc/pbus_bridge.md
# pbus_bridge

Parametrised peripheral-bus bridge between the pipelined CPU's memory stage and up to 8 memory-mapped devices (counter, LED board, seg7, UART, …). Decodes the word address against per-slot base/mask pairs, drives one-cycle device strobes, waits on a per-device ready with timeout, and returns data with a ready/error handshake. It also aggregates masked device interrupts onto `HWInt[7:2]` and exposes a small bridge register file with error capture.

## Interface
- `NUM_DEV`, 4: number of device slots, 1..8.
- `TIMEOUT`, 15: maximum ACCESS cycles before a bus error, 1..255.
- `BRIDGE_BASE`, 30'h3FFF_FF00 >> 0: word address of the bridge register block, 4 words, `PrAddr[3:2]` selects.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `PrAddr` in 30: CPU word address [31:2], held until `PrRdy`.
- `PrWD` in 32: CPU write data.
- `PrBE` in 4: byte enables.
- `PrWe` / `PrRd` in 1: request, held until `PrRdy`.
- `PrRD` out 32: read data, valid with `PrRdy`.
- `PrRdy` out 1: one-cycle completion pulse.
- `PrErr` out 1: bus error, valid with `PrRdy`.
- `DevAddr` out 30: latched word address, broadcast.
- `DevWD` out 32, `DevBE` out 4: latched write data and byte enables.
- `DevWe` / `DevRe` out NUM_DEV: one-hot, one-cycle strobes.
- `DevRD` in 32*NUM_DEV: slot i at bits [32i+31:32i].
- `DevRdy` in NUM_DEV: device completion. Tie high for zero-wait devices.
- `DevInt` in NUM_DEV: level interrupts.
- `HWInt` out 6: CPU interrupt lines [7:2].

## Operation
- FSM states are IDLE, ACCESS, RESP.
- IDLE with a request: latch addr/WD/BE/op, then decode.
  - Device hit: go to ACCESS and strobe `DevWe[i]`/`DevRe[i]` for that single cycle.
  - Bridge-block hit: perform the register access and go to RESP.
  - No hit: go to RESP with error, setting STATUS.nohit.
- Decode: slot i hits when `(PrAddr & DEV_MASK[i]) == DEV_BASE[i]`. Overlapping hits resolve to the lowest index.
- If `PrWe` and `PrRd` are both high, the access is a write.
- ACCESS: the wait counter counts from 0.
  - `DevRdy[sel]` high: capture `DevRD[sel]` (reads) and go to RESP with no error. This can happen in the strobe cycle.
  - Counter reaches `TIMEOUT-1` without ready: go to RESP with error, set STATUS.timeout, and return `PrRD`=0.
- Any error sets STATUS.err and loads ERR_ADDR.
- RESP: `PrRdy`=1 for one cycle, then IDLE. Requests are not sampled in RESP or ACCESS.
- Bridge registers:
  - 0 STATUS {timeout, nohit, err}[2:0]: write-1-to-clear. A new error set in the same cycle as the clear wins.
  - 1 ERR_ADDR {addr,2'b00}: read-only.
  - 2 INT_MASK [NUM_DEV-1:0]: read/write, reset all ones.
  - 3 ERR_IE bit0: read/write, reset 0.
  - Writes honour `PrBE`.
- Interrupts, registered one cycle:
  - `HWInt[k]` = `DevInt[k] & INT_MASK[k]` for k=0..4.
  - `HWInt[5]` = OR of masked `DevInt[5..NUM_DEV-1]`, OR (STATUS.err & ERR_IE).
  - Absent slots read as 0.

## Timing
- Reset values: `PrRD`=0, `PrRdy`=0, `PrErr`=0, strobes 0, `Dev*` latches 0, `HWInt`=0, FSM in IDLE, STATUS=0, ERR_ADDR=0.
- Reset mid-access aborts immediately. No strobe or `PrRdy` is issued afterwards.
- Latency is measured from the first request cycle N:
  - Zero-wait device: `PrRdy` at N+2.
  - Device with w wait cycles: `PrRdy` at N+2+w.
  - Timeout: `PrRdy` at N+1+TIMEOUT.
  - No-hit or bridge register: `PrRdy` at N+1.
- Back-to-back: a request still held in the cycle after `PrRdy` is treated as a new access. The CPU drops the request at `PrRdy`.
- Device interrupt to `HWInt`: 1 cycle.
- Bridge-block write to effect: next cycle.

## Structure
- `pbus_pkg` holds:
  - `DEV_BASE` / `DEV_MASK` localparam arrays (slots 0–3: 'h7F/'h80/'h81/'h82 in bits [31:8]).
  - The state enum.
  - Bridge register offsets.
  - The STATUS bit indices.
- Sub-module `pbus_irq_agg` holds the mask, fold, and output register for interrupts.

## Test plan
- Zero-wait write to slot 1 with `PrWD`=32'hA5 -> `DevWe`=4'b0010 for one cycle, `DevWD`=32'hA5, `PrRdy` at N+2, `PrErr`=0.
- Read from slot 3 with `DevRdy` delayed 3 cycles and `DevRD`=32'h1234 -> `PrRdy` at N+5, `PrRD`=32'h1234.
- Read from slot 2 with `DevRdy` stuck low and TIMEOUT=15 -> `PrRdy`/`PrErr` at N+16, `PrRD`=0, STATUS=3'b101, ERR_ADDR equals the address.
- Access to an unmapped address -> `PrRdy`/`PrErr` at N+1, STATUS.nohit=1. A W1C write of 3'b111 clears STATUS. An error in the same cycle as the clear leaves STATUS set.
- INT_MASK=4'b1011 with `DevInt`=4'b1111 -> `HWInt`=6'b001011 one cycle later. ERR_IE=1 plus an error -> `HWInt[5]`=1.
- Assert `rst` during ACCESS -> outputs return to zero immediately, and no `PrRdy` pulse appears.
